fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC generator and fetch buffer directly upstream of the instruction memory.
//  Drives the word address to the combinational instruction ROM, captures {pc, inst} into a small FIFO,
//  and hands entries to decode over a valid/ready handshake.
//  Accepts redirects (jumps/branches) from execute, which flush the buffer and restart fetch at the target.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  DEPTH       4              fetch FIFO entries (power of 2, >=2)
//  IMEM_WORDS  32768          implemented instruction words; PC >= IMEM_WORDS*4 is a fetch fault
// PORTS
//  clk             in   1   sole clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_addr       out  32  byte address to instruction memory (= pc_q)
//  imem_inst       in   32  instruction word returned combinationally, same cycle
//  redirect_valid  in   1   execute requests a PC change this cycle
//  redirect_pc     in   32  redirect target; bits[1:0] ignored (treated as 0)
//  out_valid       out  1   FIFO head holds a valid entry
//  out_ready       in   1   decode accepts head this cycle
//  out_pc          out  32  PC of head entry
//  out_inst        out  32  instruction of head entry
//  fetch_fault     out  1   fetch stopped on out-of-range PC; held until redirect
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, FIFO empty, state=RUN.
//   out_valid=0, fetch_fault=0, out_pc/out_inst=0.
//  FSM: RUN -> FAULT when state==RUN, pc_q>=IMEM_WORDS*4, no redirect.
//   FAULT -> RUN on redirect_valid. FAULT never pushes; pc_q holds.
//  push = state==RUN && pc_q in range && !redirect_valid && (count<DEPTH || pop).
//   Push writes {pc_q, imem_inst} at the edge and sets pc_q <= pc_q+4 (mod 2^32 wrap).
//   No push: pc_q holds.
//  pop = out_valid && out_ready; the head advances at the edge.
//   Push and pop may occur in the same cycle, including when full; count is unchanged.
//  Latency: an entry fetched in cycle N is visible on out_* in cycle N+1. No same-cycle bypass.
//  Redirect in cycle N (wins over everything):
//   - FIFO cleared; any cycle-N pop is irrelevant.
//   - pc_q <= {redirect_pc[31:2],2'b00}; state<=RUN; fetch_fault<=0.
//   - The cycle-N imem_inst is discarded.
//   - Target fetched in N+1; out_valid=1 in N+2 at the earliest.
//  out_* driven from registered FIFO storage. Outputs are stable while out_valid && !out_ready.
//  fetch_fault is registered: asserted the cycle after entering FAULT.
//  Entries already buffered before a fault still drain normally.
//  rst mid-operation overrides redirect and all traffic: full reset state next cycle.
//  count range 0..DEPTH; pointers wrap modulo DEPTH.
// STRUCTURE
//  fetch_pkg:
//   - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t
//   - typedef enum logic {FS_RUN, FS_FAULT} fetch_state_t
//   - localparam INST_BYTES=4
//  Sub-module fetch_fifo #(DEPTH, fetch_entry_t):
//   - ports: push/pop/flush, full/empty, head
//   - flush dominates push/pop
//  Top keeps pc_q, FSM, range check and push/pop logic only.
// TESTING
//  1 Reset, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44:
//    out_valid rises 1 cycle after reset release; pcs 0,4,8,C in consecutive cycles.
//  2 out_ready=0 from reset: exactly DEPTH=4 pushes, imem_addr stalls at 0x10.
//    Then out_ready=1 for 1 cycle: head 0x0 popped, entry 0x10 pushed same cycle, imem_addr=0x14.
//  3 redirect_valid with redirect_pc=0x103 while FIFO holds 3 entries:
//    next cycle out_valid=0, imem_addr=0x100; following cycle out_pc=0x100.
//  4 IMEM_WORDS=8, run from 0: entries 0x0..0x1C delivered; imem_addr stops at 0x20.
//    fetch_fault=1 and held; redirect to 0x4 clears the fault and fetch resumes at 0x4.
//  5 rst asserted mid-stream while redirect_valid=1:
//    next cycle pc=RESET_PC, out_valid=0, fetch_fault=0, redirect ignored.
//  6 RESET_PC=0xFFFF_FFFC, IMEM_WORDS large enough to cover it:
//    after one push pc_q wraps to 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its buffer.
package fetch_pkg;

   localparam int unsigned INST_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   typedef enum logic {
      FS_RUN,
      FS_FAULT
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
interface fetch_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        fetch_fault;

   modport master (
      output imem_addr,
      input  imem_inst,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_inst,
      output fetch_fault
   );

   modport slave (
      input  imem_addr,
      output imem_inst,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_inst,
      input  fetch_fault
   );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular buffer of fetched entries; flush dominates push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = fetch_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  T     din,
   output logic full,
   output logic empty,
   output T     head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   T              mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   // Empty reads as zero so the reset/flush view of the head is deterministic.
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// PC generator feeding a combinational instruction ROM, buffering {pc, inst}
// for decode and restarting on execute redirects.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned IMEM_WORDS = 32768
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master fs
);

   // 34 bits so a ROM covering the whole 4 GiB space does not overflow the limit.
   localparam logic [33:0] PC_LIMIT = 34'(IMEM_WORDS) * 34'(INST_BYTES);

   fetch_state_t state_q;
   fetch_state_t state_d;
   logic [31:0]  pc_q;
   logic         fault_q;
   logic         in_range;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   fetch_entry_t din;
   fetch_entry_t head;

   assign in_range = ({2'b00, pc_q} < PC_LIMIT);
   assign pop      = !empty && fs.out_ready;
   assign din      = '{pc: pc_q, inst: fs.imem_inst};

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      unique case (state_q)
         FS_RUN: begin
            if (fs.redirect_valid) begin
               state_d = FS_RUN;
            end else if (!in_range) begin
               state_d = FS_FAULT;
            end else begin
               push = !full || pop;
            end
         end
         FS_FAULT: begin
            if (fs.redirect_valid) state_d = FS_RUN;
         end
         default: state_d = FS_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_RUN;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= (state_d == FS_FAULT);
         if (fs.redirect_valid) begin
            pc_q <= fs.redirect_pc & ~32'h3;
         end else if (push) begin
            pc_q <= pc_q + 32'(INST_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (fs.redirect_valid),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   assign fs.imem_addr   = pc_q;
   assign fs.out_valid   = !empty;
   assign fs.out_pc      = head.pc;
   assign fs.out_inst    = head.inst;
   assign fs.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned IMEM_WORDS = 128;
   localparam logic [31:0] LIMIT      = 32'h200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst2;

   fetch_stage_if fs();
   fetch_stage_if ws();

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .DEPTH      (DEPTH),
      .IMEM_WORDS (IMEM_WORDS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fs  (fs)
   );

   fetch_stage #(
      .RESET_PC   (32'hFFFF_FFFC),
      .DEPTH      (2),
      .IMEM_WORDS (32'h4000_0000)
   ) dut_wrap (
      .clk (clk),
      .rst (rst2),
      .fs  (ws)
   );

   logic [31:0] mem [128];

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a < LIMIT) return mem[a[8:2]];
      return 32'hDEAD_BEEF;
   endfunction

   always_comb fs.imem_inst = rom(fs.imem_addr);

   assign ws.imem_inst      = ~ws.imem_addr;
   assign ws.redirect_valid = 1'b0;
   assign ws.redirect_pc    = 32'h0;
   assign ws.out_ready      = 1'b1;

   // Reference model state: current fetch PC, fault flag, buffer contents,
   // and the stream of entries decode is still expected to receive.
   logic [31:0]  m_pc;
   bit           m_fault;
   fetch_entry_t mq[$];
   fetch_entry_t sb[$];
   fetch_entry_t mon_e;
   bit           checking;
   int           vectors;
   int           miscompares;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check("out_valid", 32'(fs.out_valid), 32'(sb.size() != 0));
         check("imem_addr", fs.imem_addr, m_pc);
         check("fetch_fault", 32'(fs.fetch_fault), 32'(m_fault));
         if (fs.out_valid === 1'b1 && fs.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_entry: got pc %h expected no entry", fs.out_pc);
            end else begin
               mon_e = sb.pop_front();
               check("out_pc", fs.out_pc, mon_e.pc);
               check("out_inst", fs.out_inst, mon_e.inst);
            end
         end
      end
   end

   task automatic model_step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      fetch_entry_t e;
      if (r) begin
         m_pc    = 32'h0;
         m_fault = 1'b0;
         mq.delete();
         sb.delete();
      end else if (rv) begin
         m_pc    = {rpc[31:2], 2'b00};
         m_fault = 1'b0;
         mq.delete();
         sb.delete();
      end else begin
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (!m_fault) begin
            if (m_pc >= LIMIT) begin
               m_fault = 1'b1;
            end else if (mq.size() < DEPTH) begin
               e.pc   = m_pc;
               e.inst = rom(m_pc);
               mq.push_back(e);
               sb.push_back(e);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
      rst               = r;
      fs.redirect_valid = rv;
      fs.redirect_pc    = rpc;
      fs.out_ready      = rdy;
      @(negedge clk);
      #2;
      model_step(r, rv, rpc, rdy);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          r;
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      int unsigned ready_pct;

      vectors     = 0;
      miscompares = 0;
      checking    = 1'b0;
      m_pc        = 32'h0;
      m_fault     = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      mem[3] = 32'h44;
      rst  = 1'b1;
      rst2 = 1'b1;
      fs.redirect_valid = 1'b0;
      fs.redirect_pc    = 32'h0;
      fs.out_ready      = 1'b1;
      @(posedge clk);
      #1;

      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      checking = 1'b1;
      rst2     = 1'b0;
      check("reset_out_pc", fs.out_pc, 32'h0);
      check("reset_out_inst", fs.out_inst, 32'h0);
      check("wrap_start_addr", ws.imem_addr, 32'hFFFF_FFFC);

      // Streaming from reset with decode always ready.
      cycle(0, 0, 0, 1);
      check("wrap_addr", ws.imem_addr, 32'h0000_0000);
      check("wrap_out_valid", 32'(ws.out_valid), 32'h1);
      check("wrap_out_pc", ws.out_pc, 32'hFFFF_FFFC);
      check("wrap_out_inst", ws.out_inst, 32'h0000_0003);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

      // Decode stalled from reset, then a single accept while full.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
      check("stall_addr", fs.imem_addr, 32'h10);
      cycle(0, 0, 0, 1);
      check("full_pushpop_addr", fs.imem_addr, 32'h14);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

      // Redirect with a partially filled buffer; low target bits ignored.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 32'h103, 1);
      check("redirect_addr", fs.imem_addr, 32'h100);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);

      // Run off the end of the ROM, hold the fault, then recover.
      cycle(0, 1, 32'h1F0, 1);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1);
      check("fault_addr", fs.imem_addr, LIMIT);
      check("fault_flag", 32'(fs.fetch_fault), 32'h1);
      cycle(0, 1, 32'h4, 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);

      // Reset overrides a simultaneous redirect.
      cycle(1, 1, 32'h80, 1);
      check("rst_redirect_addr", fs.imem_addr, 32'h0);
      check("rst_redirect_pc", fs.out_pc, 32'h0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

      ready_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) ready_pct = $urandom_range(10, 100);
         r   = ($urandom_range(0, 199) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = $urandom_range(0, 32'h23F);
         rdy = ($urandom_range(1, 100) <= ready_pct);
         cycle(r, rv, rpc, rdy);
      end

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
